// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition trigger sequencer.
//   acq_state_t : sequencer state codes, also driven on STATE_out
//   FIFO word   : {trg_mark[15], 1'b0[14], sample[13:0]}
//   fifo_word() : packs a mark bit and a sample into a FIFO word
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_QUALIFY  = 3'd2,
        ST_WAIT_TRG = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_DONE     = 3'd5
    } acq_state_t;

    localparam int unsigned FIFO_W   = 16;
    localparam int unsigned MARK_BIT = 15;
    localparam int unsigned SAMPLE_W = 14;

    function automatic logic [FIFO_W-1:0] fifo_word(input logic mark,
                                                    input logic [SAMPLE_W-1:0] sample);
        logic [FIFO_W-1:0] w;
        w                 = '0;
        w[MARK_BIT]       = mark;
        w[SAMPLE_W-1:0]   = sample;
        return w;
    endfunction

endpackage

// File: rtl/sample_delay_line.sv
// Pre-trigger delay line: DEPTH-deep shift register of DATA_W samples.
//   clk, rst : clock, asynchronous active-high reset
//   en       : shift enable (one position per enabled cycle)
//   din      : sample entering the line
//   dout     : sample that entered DEPTH enabled cycles ago
module sample_delay_line #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] taps [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else if (en) begin
            taps[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/acq_trigger_sequencer.sv
// Acquisition sequencer: arms on START, fills the pre-trigger delay line,
// applies a low-then-high hysteresis trigger and writes a PRE_LEN+POST_LEN
// word window into the capture FIFO.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   START_in         : arm/restart pulse
//   SLEEP_n_in       : low forces IDLE (wins over START)
//   TRGLEVEL_in      : {H, L} trigger levels, latched at START
//   ADC_in/valid     : sample stream
//   full_in          : FIFO full; writes are dropped and OVF set
//   FIFO_wr_out/data : FIFO write strobe and {mark, 0, sample} word
//   STATE_out        : current state code
//   DONE_out/OVF_out : capture complete / sticky dropped-write flag
//   TRG_out          : one-cycle trigger pulse, aligned with word 0
import acq_pkg::*;

module acq_trigger_sequencer #(
    parameter int unsigned DATA_W   = 14,
    parameter int unsigned PRE_LEN  = 16,
    parameter int unsigned POST_LEN = 240,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                START_in,
    input  logic                SLEEP_n_in,
    input  logic [2*DATA_W-1:0] TRGLEVEL_in,
    input  logic [DATA_W-1:0]   ADC_in,
    input  logic                ADC_valid_in,
    input  logic                full_in,
    output logic                FIFO_wr_out,
    output logic [FIFO_W-1:0]   FIFO_data_out,
    output logic [2:0]          STATE_out,
    output logic                DONE_out,
    output logic                OVF_out,
    output logic                TRG_out
);

    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] MARK_IDX  = CNT_W'(PRE_LEN);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(PRE_LEN + POST_LEN - 1);

    acq_state_t        state;
    logic [DATA_W-1:0] h_lat;
    logic [DATA_W-1:0] l_lat;
    logic [CNT_W-1:0]  fill_cnt;
    logic [CNT_W-1:0]  win_cnt;
    logic [DATA_W-1:0] dly_out;

    logic trig_hit;
    logic cap_hit;
    logic write_req;
    logic write_mark;

    sample_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (PRE_LEN)
    ) u_delay (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .en   (ADC_valid_in),
        .din  (ADC_in),
        .dout (dly_out)
    );

    // Trigger cycle writes word 0; later capture words carry the mark at
    // index PRE_LEN. Stop/start suppress any write in the same cycle.
    always_comb begin
        trig_hit   = (state == ST_WAIT_TRG) && ADC_valid_in && (ADC_in >= h_lat);
        cap_hit    = (state == ST_CAPTURE) && ADC_valid_in;
        write_req  = SLEEP_n_in && !START_in && (trig_hit || cap_hit);
        write_mark = cap_hit && (win_cnt == MARK_IDX);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            h_lat         <= '0;
            l_lat         <= '0;
            fill_cnt      <= '0;
            win_cnt       <= '0;
            FIFO_wr_out   <= 1'b0;
            FIFO_data_out <= '0;
            DONE_out      <= 1'b0;
            OVF_out       <= 1'b0;
            TRG_out       <= 1'b0;
        end else begin
            FIFO_wr_out <= 1'b0;
            TRG_out     <= 1'b0;

            if (!SLEEP_n_in) begin
                state    <= ST_IDLE;
                DONE_out <= 1'b0;
            end else if (START_in) begin
                h_lat    <= TRGLEVEL_in[2*DATA_W-1:DATA_W];
                l_lat    <= TRGLEVEL_in[DATA_W-1:0];
                fill_cnt <= '0;
                win_cnt  <= '0;
                OVF_out  <= 1'b0;
                DONE_out <= 1'b0;
                state    <= ST_FILL;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_FILL: begin
                        if (ADC_valid_in) begin
                            if (fill_cnt == FILL_LAST) begin
                                state <= ST_QUALIFY;
                            end else begin
                                fill_cnt <= fill_cnt + 1'b1;
                            end
                        end
                    end
                    ST_QUALIFY: begin
                        if (ADC_valid_in && (ADC_in <= l_lat)) begin
                            state <= ST_WAIT_TRG;
                        end
                    end
                    ST_WAIT_TRG: begin
                        if (trig_hit) begin
                            TRG_out <= 1'b1;
                            win_cnt <= CNT_W'(1);
                            state   <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (cap_hit) begin
                            win_cnt <= win_cnt + 1'b1;
                            if (win_cnt == WIN_LAST) begin
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: DONE_out <= 1'b1;
                    default: state <= ST_IDLE;
                endcase
            end

            // Window position advances even when the word is dropped on full.
            if (write_req) begin
                if (full_in) begin
                    OVF_out <= 1'b1;
                end else begin
                    FIFO_wr_out   <= 1'b1;
                    FIFO_data_out <= fifo_word(write_mark, dly_out);
                end
            end
        end
    end

    assign STATE_out = state;

endmodule

// File: tb/tb_acq_trigger_sequencer.sv
module tb_acq_trigger_sequencer;

    localparam int DATA_W = 14;

    logic                sys_clk;
    logic                sys_rst;
    logic                START_in;
    logic                SLEEP_n_in;
    logic [2*DATA_W-1:0] TRGLEVEL_in;
    logic [DATA_W-1:0]   ADC_in;
    logic                ADC_valid_in;
    logic                full_in;
    logic                FIFO_wr_out;
    logic [15:0]         FIFO_data_out;
    logic [2:0]          STATE_out;
    logic                DONE_out;
    logic                OVF_out;
    logic                TRG_out;

    int checks;
    int errors;
    int wr_count;
    int trg_count;
    logic [15:0] exp_q [$];

    acq_trigger_sequencer #(
        .DATA_W   (DATA_W),
        .PRE_LEN  (4),
        .POST_LEN (8),
        .CNT_W    (16)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .START_in      (START_in),
        .SLEEP_n_in    (SLEEP_n_in),
        .TRGLEVEL_in   (TRGLEVEL_in),
        .ADC_in        (ADC_in),
        .ADC_valid_in  (ADC_valid_in),
        .full_in       (full_in),
        .FIFO_wr_out   (FIFO_wr_out),
        .FIFO_data_out (FIFO_data_out),
        .STATE_out     (STATE_out),
        .DONE_out      (DONE_out),
        .OVF_out       (OVF_out),
        .TRG_out       (TRG_out)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: inputs already applied, outputs sampled on the falling edge.
    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
        if (FIFO_wr_out === 1'b1) begin
            wr_count++;
            chk("done_low_during_write", {31'd0, DONE_out}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("write_when_none_expected", {31'd0, FIFO_wr_out}, 32'd0);
            end else begin
                chk("fifo_word", {16'd0, FIFO_data_out}, {16'd0, exp_q.pop_front()});
            end
        end
        if (TRG_out === 1'b1) begin
            trg_count++;
            chk("trg_with_write", {31'd0, FIFO_wr_out}, 32'd1);
        end
    endtask

    task automatic drive(input logic valid, input int value);
        ADC_valid_in = valid;
        ADC_in       = DATA_W'(value);
        tick();
        if (!valid) chk("no_write_on_invalid", {31'd0, FIFO_wr_out}, 32'd0);
    endtask

    task automatic set_levels(input int low, input int high);
        TRGLEVEL_in = {DATA_W'(high), DATA_W'(low)};
    endtask

    task automatic pulse_start();
        START_in     = 1'b1;
        ADC_valid_in = 1'b0;
        tick();
        START_in     = 1'b0;
        wr_count     = 0;
        trg_count    = 0;
    endtask

    // Ramp 0,10,20... with L=100/H=200: trigger at i=20, word k at i=20+k,
    // word k carries sample 160+10k, word 4 is marked.
    task automatic push_ramp_words(input int last_k, input int skip_lo, input int skip_hi);
        logic [15:0] w;
        for (int k = 0; k <= last_k; k++) begin
            if (k < skip_lo || k > skip_hi) begin
                w        = 16'(160 + 10 * k);
                w[15]    = (k == 4);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic ramp(input int last_i, input int full_from, input int full_to,
                        input int sleep_from, input bit gaps);
        for (int i = 0; i <= last_i; i++) begin
            full_in    = (i >= full_from) && (i <= full_to);
            SLEEP_n_in = !(i >= sleep_from);
            drive(1'b1, 10 * i);
            if (gaps) drive(1'b0, 16383);
        end
        full_in    = 1'b0;
        SLEEP_n_in = 1'b1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        wr_count     = 0;
        trg_count    = 0;
        sys_rst      = 1'b1;
        START_in     = 1'b0;
        SLEEP_n_in   = 1'b1;
        TRGLEVEL_in  = '0;
        ADC_in       = '0;
        ADC_valid_in = 1'b0;
        full_in      = 1'b0;

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_state", {29'd0, STATE_out}, 32'd0);
        chk("rst_wr", {31'd0, FIFO_wr_out}, 32'd0);
        chk("rst_data", {16'd0, FIFO_data_out}, 32'd0);
        chk("rst_done", {31'd0, DONE_out}, 32'd0);
        chk("rst_ovf", {31'd0, OVF_out}, 32'd0);
        chk("rst_trg", {31'd0, TRG_out}, 32'd0);
        sys_rst = 1'b0;
        drive(1'b1, 5);
        chk("idle_without_start", {29'd0, STATE_out}, 32'd0);

        // Ramp capture
        set_levels(100, 200);
        pulse_start();
        chk("start_to_fill", {29'd0, STATE_out}, 32'd1);
        push_ramp_words(11, 99, 99);
        ramp(32, 99, -1, 999, 1'b0);
        chk("ramp_done", {31'd0, DONE_out}, 32'd1);
        chk("ramp_state_done", {29'd0, STATE_out}, 32'd5);
        chk("ramp_writes", wr_count, 32'd12);
        chk("ramp_trg_count", trg_count, 32'd1);
        chk("ramp_ovf", {31'd0, OVF_out}, 32'd0);
        chk("ramp_queue_empty", exp_q.size(), 32'd0);

        // Qualify required
        pulse_start();
        for (int i = 0; i < 14; i++) drive(1'b1, 300);
        chk("qual_hold_high", {29'd0, STATE_out}, 32'd2);
        chk("qual_no_writes", wr_count, 32'd0);
        exp_q.push_back(16'd50);
        exp_q.push_back(16'd100);
        exp_q.push_back(16'd150);
        exp_q.push_back(16'd190);
        exp_q.push_back(16'h8000 | 16'd250);
        for (int k = 0; k < 7; k++) exp_q.push_back(16'(260 + 10 * k));
        drive(1'b1, 50);
        chk("qual_low_to_wait", {29'd0, STATE_out}, 32'd3);
        drive(1'b1, 100);
        drive(1'b1, 150);
        drive(1'b1, 190);
        chk("qual_no_trg_below_h", trg_count, 32'd0);
        drive(1'b1, 250);
        chk("qual_trg", {31'd0, TRG_out}, 32'd1);
        for (int j = 0; j <= 10; j++) drive(1'b1, 260 + 10 * j);
        drive(1'b1, 0);
        chk("qual_done", {31'd0, DONE_out}, 32'd1);
        chk("qual_writes", wr_count, 32'd12);
        chk("qual_queue_empty", exp_q.size(), 32'd0);

        // Full during words 2-3
        pulse_start();
        chk("full_ovf_cleared", {31'd0, OVF_out}, 32'd0);
        push_ramp_words(11, 2, 3);
        ramp(32, 22, 23, 999, 1'b0);
        chk("full_writes", wr_count, 32'd10);
        chk("full_ovf", {31'd0, OVF_out}, 32'd1);
        chk("full_done_on_time", {31'd0, DONE_out}, 32'd1);
        chk("full_queue_empty", exp_q.size(), 32'd0);

        // Stop after word 5 (word 1 dropped so OVF must be retained)
        pulse_start();
        push_ramp_words(5, 1, 1);
        ramp(30, 21, 21, 26, 1'b0);
        chk("stop_state", {29'd0, STATE_out}, 32'd0);
        chk("stop_done", {31'd0, DONE_out}, 32'd0);
        chk("stop_ovf_kept", {31'd0, OVF_out}, 32'd1);
        chk("stop_writes", wr_count, 32'd5);
        chk("stop_queue_empty", exp_q.size(), 32'd0);

        // Start together with sleep: stop wins
        SLEEP_n_in = 1'b0;
        START_in   = 1'b1;
        drive(1'b1, 0);
        START_in   = 1'b0;
        SLEEP_n_in = 1'b1;
        drive(1'b1, 0);
        chk("start_vs_sleep", {29'd0, STATE_out}, 32'd0);

        // Restart during WAIT_TRG; new levels latched, later changes ignored
        set_levels(100, 200);
        pulse_start();
        for (int i = 0; i <= 8; i++) drive(1'b1, 10 * i);
        chk("rs_wait", {29'd0, STATE_out}, 32'd3);
        pulse_start();
        set_levels(0, 1000);
        exp_q.push_back(16'd70);
        exp_q.push_back(16'd80);
        exp_q.push_back(16'd250);
        exp_q.push_back(16'd90);
        exp_q.push_back(16'h8000 | 16'd210);
        for (int k = 0; k < 7; k++) exp_q.push_back(16'(220 + 10 * k));
        drive(1'b1, 50);
        drive(1'b1, 60);
        drive(1'b1, 70);
        drive(1'b1, 80);
        chk("rs_fill_done", {29'd0, STATE_out}, 32'd2);
        drive(1'b1, 250);
        chk("rs_no_trg_in_qualify", {29'd0, STATE_out}, 32'd2);
        drive(1'b1, 90);
        chk("rs_qualified", {29'd0, STATE_out}, 32'd3);
        drive(1'b1, 210);
        chk("rs_trg", {31'd0, TRG_out}, 32'd1);
        for (int j = 0; j <= 10; j++) drive(1'b1, 220 + 10 * j);
        drive(1'b1, 0);
        chk("rs_done", {31'd0, DONE_out}, 32'd1);
        chk("rs_writes", wr_count, 32'd12);
        chk("rs_queue_empty", exp_q.size(), 32'd0);

        // Gapped valid: same words as the continuous ramp
        set_levels(100, 200);
        pulse_start();
        push_ramp_words(11, 99, 99);
        ramp(32, 99, -1, 999, 1'b1);
        chk("gap_done", {31'd0, DONE_out}, 32'd1);
        chk("gap_writes", wr_count, 32'd12);
        chk("gap_trg_count", trg_count, 32'd1);
        chk("gap_queue_empty", exp_q.size(), 32'd0);

        // Asynchronous reset mid-capture
        pulse_start();
        push_ramp_words(4, 99, 99);
        ramp(24, 99, -1, 999, 1'b0);
        chk("pre_rst_wr", {31'd0, FIFO_wr_out}, 32'd1);
        chk("pre_rst_state", {29'd0, STATE_out}, 32'd4);
        sys_rst = 1'b1;
        #1;
        chk("arst_wr", {31'd0, FIFO_wr_out}, 32'd0);
        chk("arst_data", {16'd0, FIFO_data_out}, 32'd0);
        chk("arst_state", {29'd0, STATE_out}, 32'd0);
        chk("arst_trg_done_ovf", {29'd0, TRG_out, DONE_out, OVF_out}, 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        drive(1'b1, 0);
        chk("post_rst_idle", {29'd0, STATE_out}, 32'd0);
        chk("rst_queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
